panxi_pipe_skid: RTL and testbench

- Two-entry, full-throughput valid/ready pipeline register stage.
- Sits between any producer and consumer in the core datapath, e.g. IF->ID or ID->EX.
- The upstream side is the receiver and the downstream side is the transmitter; both handshake signals leaving the block (i_ready, o_valid) are registered, which breaks the ready and valid timing paths.
- Data storage is built from the team's enable-type flip-flop primitives.

---
 rtl/panxi_pipe_pkg.sv | 13 +
 rtl/panxi_pipe_skid_dff.sv | 42 ++++
 rtl/panxi_pipe_skid.sv | 121 ++++++++++++
 tb/tb_panxi_pipe_skid.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/panxi_pipe_pkg.sv
// Shared types and constants for the panxi valid/ready pipeline stage.
// Holds the occupancy state encoding used by the state register.
package panxi_pipe_pkg;

    localparam int PIPE_ST_W = 2;

    typedef enum logic [PIPE_ST_W-1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/panxi_pipe_skid_dff.sv
// Flip-flop primitives: panxi_dffr (async-reset) and panxi_dffer (async-reset with enable).
// Both reset to RST_VAL on a falling rstn without waiting for clk.
module panxi_dffr #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

module panxi_dffer #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/panxi_pipe_skid.sv
// Two-entry valid/ready skid stage: main register drives o_data, skid catches the
// payload accepted while the consumer stalls. Both outgoing handshakes are registered.
module panxi_pipe_skid
    import panxi_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o_data
);

    logic [PIPE_ST_W-1:0] state_bits_q;
    pipe_state_e          state_q;
    pipe_state_e          state_d;
    logic                 main_en;
    logic                 skid_en;
    logic [WIDTH-1:0]     main_d;
    logic [WIDTH-1:0]     main_q;
    logic [WIDTH-1:0]     skid_q;
    logic                 o_valid_q;
    logic                 o_valid_d;
    logic                 i_ready_q;
    logic                 i_ready_d;
    logic                 in_fire;
    logic                 out_fire;

    assign state_q  = pipe_state_e'(state_bits_q);
    assign in_fire  = i_valid & i_ready_q;
    assign out_fire = o_valid_q & o_ready;

    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = i_data;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = BUSY;
                    main_en = 1'b1;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_en = 1'b1;
                end else if (in_fire) begin
                    state_d = FULL;
                    skid_en = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d = BUSY;
                    main_en = 1'b1;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush drops everything, including a payload offered this cycle.
        if (flush) begin
            state_d = EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
        o_valid_d = (state_d != EMPTY);
        i_ready_d = (state_d != FULL);
    end

    panxi_dffr #(.WIDTH(PIPE_ST_W), .RST_VAL(PIPE_ST_W'(EMPTY))) u_state_reg (
        .clk  (clk),
        .rstn (rstn),
        .d    (state_d),
        .q    (state_bits_q)
    );

    panxi_dffer #(.WIDTH(WIDTH)) u_main_reg (
        .clk  (clk),
        .rstn (rstn),
        .en   (main_en),
        .d    (main_d),
        .q    (main_q)
    );

    panxi_dffer #(.WIDTH(WIDTH)) u_skid_reg (
        .clk  (clk),
        .rstn (rstn),
        .en   (skid_en),
        .d    (i_data),
        .q    (skid_q)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_valid_q <= 1'b0;
            i_ready_q <= 1'b1;
        end else begin
            o_valid_q <= o_valid_d;
            i_ready_q <= i_ready_d;
        end
    end

    assign o_valid = o_valid_q;
    assign i_ready = i_ready_q;
    assign o_data  = main_q;

`ifndef SYNTHESIS
    x_check_ctrl: assert property (@(posedge clk) disable iff (!rstn)
        !$isunknown({i_valid, o_ready, flush}));
`endif

endmodule

// File: tb/tb_panxi_pipe_skid.sv
// Directed and randomized checks for panxi_pipe_skid: streaming, stall, flush,
// asynchronous reset, idle behaviour, and an ordering scoreboard over 10k payloads.
module tb_panxi_pipe_skid;

    localparam int WIDTH  = 32;
    localparam int N_RAND = 10000;
    localparam int BUDGET = 60000;

    logic             clk;
    logic             rstn;
    logic             flush;
    logic             i_valid;
    logic             i_ready;
    logic [WIDTH-1:0] i_data;
    logic             o_valid;
    logic             o_ready;
    logic [WIDTH-1:0] o_data;

    int n_pass;
    int n_total;

    panxi_pipe_skid #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .flush   (flush),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn    = 1'b0;
        flush   = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        o_ready = 1'b0;
        step();
        step();
        n_total++;
        if (o_valid !== 1'b0) $display("FAIL reset_o_valid got=%b want=0", o_valid); else n_pass++;
        n_total++;
        if (i_ready !== 1'b1) $display("FAIL reset_i_ready got=%b want=1", i_ready); else n_pass++;
        n_total++;
        if (o_data !== 32'h0) $display("FAIL reset_o_data got=%h want=0", o_data); else n_pass++;
        rstn = 1'b1;
        step();
        $display("reset: o_valid=%b i_ready=%b o_data=%h", o_valid, i_ready, o_data);
    endtask

    task automatic test_stream();
        logic [WIDTH-1:0] vec [3];
        vec[0] = 32'h11;
        vec[1] = 32'h22;
        vec[2] = 32'h33;
        o_ready = 1'b1;
        i_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_data = vec[k];
            step();
            n_total++;
            if (o_valid !== 1'b1) $display("FAIL stream_o_valid[%0d] got=%b want=1", k, o_valid); else n_pass++;
            n_total++;
            if (o_data !== vec[k]) $display("FAIL stream_o_data[%0d] got=%h want=%h", k, o_data, vec[k]); else n_pass++;
            n_total++;
            if (i_ready !== 1'b1) $display("FAIL stream_i_ready[%0d] got=%b want=1", k, i_ready); else n_pass++;
            $display("stream: out %h", o_data);
        end
        i_valid = 1'b0;
        step();
        n_total++;
        if (o_valid !== 1'b0) $display("FAIL stream_drain got=%b want=0", o_valid); else n_pass++;
    endtask

    task automatic test_stall();
        o_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'hA5;
        step();
        i_data = 32'h5A;
        step();
        n_total++;
        if (i_ready !== 1'b0) $display("FAIL stall_i_ready got=%b want=0", i_ready); else n_pass++;
        n_total++;
        if (o_data !== 32'hA5) $display("FAIL stall_o_data got=%h want=a5", o_data); else n_pass++;
        i_valid = 1'b0;
        i_data  = 32'hEE;
        step();
        n_total++;
        if (o_valid !== 1'b1 || o_data !== 32'hA5)
            $display("FAIL stall_hold got=%b/%h want=1/a5", o_valid, o_data);
        else n_pass++;
        $display("stall: out %h", o_data);
        o_ready = 1'b1;
        step();
        n_total++;
        if (o_data !== 32'h5A) $display("FAIL stall_second got=%h want=5a", o_data); else n_pass++;
        n_total++;
        if (i_ready !== 1'b1) $display("FAIL stall_ready_back got=%b want=1", i_ready); else n_pass++;
        $display("stall: out %h", o_data);
        step();
        n_total++;
        if (o_valid !== 1'b0) $display("FAIL stall_empty got=%b want=0", o_valid); else n_pass++;
    endtask

    task automatic test_flush();
        o_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'h01;
        step();
        i_data = 32'h02;
        step();
        n_total++;
        if (i_ready !== 1'b0) $display("FAIL flush_prefull got=%b want=0", i_ready); else n_pass++;
        flush  = 1'b1;
        i_data = 32'h03;
        step();
        flush = 1'b0;
        n_total++;
        if (o_valid !== 1'b0) $display("FAIL flush_o_valid got=%b want=0", o_valid); else n_pass++;
        n_total++;
        if (i_ready !== 1'b1) $display("FAIL flush_i_ready got=%b want=1", i_ready); else n_pass++;
        i_valid = 1'b0;
        o_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_total++;
            if (o_valid !== 1'b0) $display("FAIL flush_leak[%0d] got=%b data=%h want=0", k, o_valid, o_data); else n_pass++;
        end
        $display("flush: stage empty, o_valid=%b", o_valid);
    endtask

    task automatic test_async_reset();
        o_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'h44;
        step();
        i_data = 32'h55;
        step();
        i_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        n_total++;
        if (o_valid !== 1'b0) $display("FAIL arst_o_valid got=%b want=0", o_valid); else n_pass++;
        n_total++;
        if (i_ready !== 1'b1) $display("FAIL arst_i_ready got=%b want=1", i_ready); else n_pass++;
        n_total++;
        if (o_data !== 32'h0) $display("FAIL arst_o_data got=%h want=0", o_data); else n_pass++;
        step();
        rstn    = 1'b1;
        o_ready = 1'b1;
        step();
        i_valid = 1'b1;
        i_data  = 32'h77;
        step();
        i_valid = 1'b0;
        n_total++;
        if (o_valid !== 1'b1 || o_data !== 32'h77)
            $display("FAIL arst_next got=%b/%h want=1/77", o_valid, o_data);
        else n_pass++;
        $display("arst: out %h", o_data);
        step();
        n_total++;
        if (o_valid !== 1'b0) $display("FAIL arst_drain got=%b want=0", o_valid); else n_pass++;
    endtask

    task automatic test_idle();
        o_ready = 1'b1;
        i_valid = 1'b0;
        i_data  = 32'hDEAD;
        for (int k = 0; k < 3; k++) begin
            step();
            n_total++;
            if (o_valid !== 1'b0) $display("FAIL idle_o_valid[%0d] got=%b want=0", k, o_valid); else n_pass++;
        end
        $display("idle: no transfer");
    endtask

    task automatic test_random();
        int sent;
        int recv;
        int occ;
        int cyc;
        bit inf;
        bit outf;
        sent = 0;
        recv = 0;
        occ  = 0;
        cyc  = 0;
        while (recv < N_RAND && cyc < BUDGET) begin
            i_valid = (sent < N_RAND) && ($urandom_range(0, 1) == 1);
            i_data  = 32'(sent);
            o_ready = ($urandom_range(0, 1) == 1);
            #1;
            n_total++;
            if (o_valid !== (occ != 0) || i_ready !== (occ != 2))
                $display("FAIL rand_flags cyc=%0d got=%b/%b occ=%0d", cyc, o_valid, i_ready, occ);
            else n_pass++;
            inf  = i_valid && i_ready;
            outf = o_valid && o_ready;
            if (outf) begin
                n_total++;
                if (o_data !== 32'(recv)) $display("FAIL rand_order got=%h want=%h", o_data, 32'(recv)); else n_pass++;
                recv++;
            end
            if (inf) sent++;
            occ = occ + int'(inf) - int'(outf);
            step();
            cyc++;
        end
        i_valid = 1'b0;
        n_total++;
        if (recv != N_RAND) $display("FAIL rand_count got=%0d want=%0d", recv, N_RAND); else n_pass++;
        $display("random: %0d payloads in %0d cycles", recv, cyc);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_async_reset();
        test_idle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
